// File: rtl/s2p_if.sv
// Serial and parallel valid/ready signals of the serial-to-parallel receiver.
// The master drives serial bits and consumes words; the slave is the receiver.
interface s2p_if #(
   parameter int N = 4
);
   logic         svalid;
   logic         sdata;
   logic         sready;
   logic         pvalid;
   logic         pready;
   logic [N-1:0] pdata;

   modport master (
      output svalid, sdata, pready,
      input  sready, pvalid, pdata
   );

   modport slave (
      input  svalid, sdata, pready,
      output sready, pvalid, pdata
   );
endinterface

// File: rtl/s2p.sv
// Serial-to-parallel receiver: assembles N-bit words, MSB first, from a serial
// valid/ready link. A shift register plus a holding register give two words of slack.
module s2p #(
   parameter int N = 4
) (
   input  logic  clk,
   input  logic  rstn,
   s2p_if.slave  bus
);
   localparam int CW = (N > 2) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {SHIFT, WAIT} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  count, count_nxt;
   logic [N-1:0]   shreg, shreg_nxt;
   logic [N-1:0]   hold, hold_nxt;
   logic           hold_full, hold_full_nxt;

   logic           sbeat;
   logic           pbeat;
   logic           load;
   logic [N-1:0]   word;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= SHIFT;
         count     <= '0;
         shreg     <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         shreg     <= shreg_nxt;
         hold      <= hold_nxt;
         hold_full <= hold_full_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      count_nxt     = count;
      shreg_nxt     = shreg;
      hold_nxt      = hold;
      hold_full_nxt = hold_full;
      load          = 1'b0;
      sbeat         = bus.svalid && (state == SHIFT);
      pbeat         = hold_full && bus.pready;
      word          = {shreg[N-2:0], bus.sdata};

      case (state)
         SHIFT: begin
            if (sbeat) begin
               if (count != LAST) begin
                  shreg_nxt = word;
                  count_nxt = count + 1'b1;
               end else begin
                  count_nxt = '0;
                  // Word goes straight to hold if the slot is free or frees this edge.
                  if (!hold_full || pbeat) begin
                     hold_nxt = word;
                     load     = 1'b1;
                  end else begin
                     shreg_nxt = word;
                     state_nxt = WAIT;
                  end
               end
            end
         end
         WAIT: begin
            if (pbeat) begin
               hold_nxt  = shreg;
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         default: state_nxt = SHIFT;
      endcase

      if (load)
         hold_full_nxt = 1'b1;
      else if (pbeat)
         hold_full_nxt = 1'b0;
   end

   // sready decodes state only, so no combinational path from pready or svalid.
   assign bus.sready = (state == SHIFT);
   assign bus.pvalid = hold_full;
   assign bus.pdata  = hold;
endmodule

// File: doc/s2p.md
Name: s2p

Overview:
- Serial-to-parallel receiver: the far end of the serial valid/ready link driven by the team's parallel-to-serial transmitter.
- Accepts one bit per svalid&&sready handshake, MSB first, and assembles N-bit words.
- Presents each word on a parallel valid/ready interface.
- A two-stage buffer (shift register + holding register) lets the next word stream in while the current word waits for the consumer.

Parameters:
N, 4, word width in bits (N >= 2); also the number of serial beats per word

Ports:
clk     input   1     clock; all state changes on rising edge
rstn    input   1     reset, asynchronous, active-low
svalid  input   1     serial bit valid from transmitter
sdata   input   1     serial data bit, MSB of word first
sready  output  1     receiver can accept a serial bit this cycle
pvalid  output  1     pdata holds a complete word
pready  input   1     consumer accepts pdata this cycle
pdata   output  N     assembled word; bit N-1 = first serial bit received

Behaviour:
- Reset (rstn low, async): state=SHIFT, count=0, shift register=0, holding register=0, pvalid=0, pdata=0. sready=1 while in reset, because sready decodes state.
- Internal state:
  - count: width $clog2(N), range 0..N-1, bits already in shift register.
  - shreg: N bits.
  - hold: N bits, drives pdata.
  - hold_full: drives pvalid.
- Serial beat = svalid && sready at a rising edge. Parallel beat = pvalid && pready at a rising edge.
- sready = (state==SHIFT). It is registered/state-decoded only, with no combinational path from pready or svalid to sready.
- FSM, 2 states:
  - SHIFT: receiving bits. On a serial beat:
    - count < N-1: shreg <= {shreg[N-2:0], sdata}; count <= count+1.
    - count == N-1: word W = {shreg[N-2:0], sdata}; count <= 0.
      - If hold empty, or a parallel beat occurs the same edge: hold <= W, pvalid=1, stay SHIFT.
      - Otherwise: shreg <= W, go to WAIT.
    - No serial beat: shreg and count unchanged. Gaps of any length are legal between bits.
  - WAIT: shreg holds a complete word and hold is full. sready=0.
    - On a parallel beat: hold <= shreg, pvalid stays 1, count=0, go to SHIFT.
- Parallel side, when not loading:
  - A parallel beat with no new word loaded that edge: pvalid <= 0. pdata retains its last value.
  - pvalid && !pready: pdata and pvalid hold stable. pdata changes only when a new word loads.
- Latency: the word's last bit is accepted at edge k; pvalid=1 and pdata=W are visible after edge k (cycle k+1).
- Throughput: with pready held high, a word completes every N serial beats with zero bubbles and sready stays 1.
- Back-pressure: with pready low, the receiver absorbs exactly 2 words (hold + shreg), then drops sready.
  - sready returns to 1 on the cycle after the first parallel beat.
- Simultaneous last serial bit and parallel beat with hold full: new word goes straight to hold, no WAIT entry, pvalid stays 1.
- svalid while sready=0 (WAIT): ignored; no data captured.
- sdata is a don't-care when svalid=0.
- Reset mid-word or mid-WAIT: all partial and held data discarded, outputs go to their reset values immediately. The transmitter is also reset by the same rstn.
- count wraps N-1 -> 0 only on word completion. count never exceeds N-1.

Test Plan (N=4):
- Reset: assert rstn=0 mid-word after 2 bits -> pvalid=0, pdata=0, sready=1 immediately. After release, 4 bits 1,0,1,1 -> pdata=4'b1011.
- Back-to-back, pready=1: stream 4'hA then 4'h5 continuously (8 beats) -> pvalid pulses 1 cycle after beats 4 and 8, pdata=A then 5, sready never drops.
- Gapped input: bits 0,1,1,0 with svalid low 3 cycles between each -> single pvalid, pdata=4'h6, no spurious pvalid.
- Back-pressure, pready=0: send 4'h3, 4'hC, 4'h9 -> pvalid=1 with pdata=3; sready=0 after the 8th beat; 9th-word bits are not captured. Pulse pready one cycle -> pdata=C, sready=1 next cycle. Then 4'h9 is received correctly.
- Simultaneous edge: hold full with 4'h7; the 4th bit of 4'hE arrives on the same edge as pready=1 -> pdata=E next cycle, pvalid stays 1, state never WAIT.
- Transmitter loopback: connect the team's p2s (N=4) to s2p and send 16 random words -> every word is reproduced in order on pdata.
